// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the MEM-stage access unit.
//   Size encodings (SZ_*), FSM state encodings (ST_*), lane masks.
//   Optional build macro used by the top: MEM_ACCESS_STATS_EN.
package mem_access_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;   // 2'b11 decodes as word

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// lane_merge: combinational little-endian lane logic shared by the load
// and read-modify-write paths.
//   old_word  : word read from memory
//   new_data  : right-justified store data
//   offset    : byte address bits 1:0
//   size      : access size (SZ_*)
//   sign_ext  : loads only, 1 = sign-extend
//   merged    : old_word with the store lane(s) replaced
//   extracted : addressed lane(s) of old_word, extended to 32 bits
module lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] lane;

    always_comb begin
        shamt = 5'd0;
        mask  = WORD_MASK;
        case (size)
            SZ_BYTE: begin
                shamt = {offset, 3'b000};
                mask  = BYTE_MASK << shamt;
            end
            SZ_HALF: begin
                // a half always starts on lane {A1,0}
                shamt = {offset[1], 4'b0000};
                mask  = HALF_MASK << shamt;
            end
            default: ;
        endcase

        merged = (old_word & ~mask) | ((new_data << shamt) & mask);
        lane   = old_word >> shamt;

        case (size)
            SZ_BYTE: extracted = {{24{sign_ext & lane[7]}}, lane[7:0]};
            SZ_HALF: extracted = {{16{sign_ext & lane[15]}}, lane[15:0]};
            default: extracted = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: adapts MEM-stage lw/lh/lhu/lb/lbu/sw/sh/sb requests to a
// word-only data memory. Loads extract combinationally; sub-word stores run
// as a 2-cycle read-modify-write with a 1-cycle Stall.
//   Pipeline side : Address, WriteData, MemWrite, MemRead, Size, SignExt in;
//                   LoadData, Stall, MisalignErr (registered pulse) out.
//   Memory side   : MemAddress (word-aligned), MemWriteData, MemWriteEn,
//                   MemReadEn out; MemReadData in (combinational read).
//   Optional      : define MEM_ACCESS_STATS_EN to add RmwCount and
//                   MisalignCount 32-bit wrapping counters.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Size,
    input  logic              SignExt,
    output logic [DATA_W-1:0] LoadData,
    output logic              Stall,
    output logic              MisalignErr,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWriteEn,
    output logic              MemReadEn,
    input  logic [DATA_W-1:0] MemReadData
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]       RmwCount,
    output logic [31:0]       MisalignCount
`endif
);

    logic [0:0]        state;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_data;

    logic              is_word, is_half, misaligned, req, rmw_start;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] merged, extracted;

    assign is_word    = (Size != SZ_HALF) && (Size != SZ_BYTE);
    assign is_half    = (Size == SZ_HALF);
    assign misaligned = (is_half && Address[0]) || (is_word && (Address[1:0] != 2'b00));
    assign req        = MemRead || MemWrite;
    assign word_addr  = {Address[ADDR_W-1:2], 2'b00};
    assign rmw_start  = (state == ST_IDLE) && MemWrite && !misaligned && !is_word;

    lane_merge u_lane_merge (
        .old_word  (MemReadData),
        .new_data  (WriteData),
        .offset    (Address[1:0]),
        .size      (Size),
        .sign_ext  (SignExt),
        .merged    (merged),
        .extracted (extracted)
    );

    // Outputs are forced to 0 while Rst is held, including the
    // combinational ones.
    always_comb begin
        LoadData     = '0;
        Stall        = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        MemWriteEn   = 1'b0;
        MemReadEn    = 1'b0;
        if (!Rst) begin
            if (state == ST_RMW_WR) begin
                MemAddress   = rmw_addr;
                MemWriteData = rmw_data;
                MemWriteEn   = 1'b1;
            end else if (req && !misaligned) begin
                MemAddress = word_addr;
                if (MemWrite) begin
                    // store wins over a simultaneous load
                    if (is_word) begin
                        MemWriteData = WriteData;
                        MemWriteEn   = 1'b1;
                    end else begin
                        MemReadEn = 1'b1;
                        Stall     = 1'b1;
                    end
                end else begin
                    MemReadEn = 1'b1;
                    LoadData  = extracted;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= ST_IDLE;
            rmw_addr      <= '0;
            rmw_data      <= '0;
            MisalignErr   <= 1'b0;
`ifdef MEM_ACCESS_STATS_EN
            RmwCount      <= '0;
            MisalignCount <= '0;
`endif
        end else begin
            MisalignErr <= (state == ST_IDLE) && req && misaligned;
            if (rmw_start) begin
                state    <= ST_RMW_WR;
                rmw_addr <= word_addr;
                rmw_data <= merged;
            end else begin
                state <= ST_IDLE;
            end
`ifdef MEM_ACCESS_STATS_EN
            if (rmw_start)
                RmwCount <= RmwCount + 32'd1;
            if ((state == ST_IDLE) && req && misaligned)
                MisalignCount <= MisalignCount + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a behavioural word memory.
// Each driven cycle pushes its expected outputs into a queue; a monitor on
// the falling edge pops and compares.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Address, WriteData;
    logic        MemWrite, MemRead, SignExt;
    logic [1:0]  Size;
    logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;
    logic        Stall, MisalignErr, MemWriteEn, MemReadEn;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] RmwCount, MisalignCount;
`endif

    mem_access_unit dut (
        .Clk(Clk), .Rst(Rst), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .SignExt(SignExt),
        .LoadData(LoadData), .Stall(Stall), .MisalignErr(MisalignErr),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWriteEn(MemWriteEn), .MemReadEn(MemReadEn), .MemReadData(MemReadData)
`ifdef MEM_ACCESS_STATS_EN
        , .RmwCount(RmwCount), .MisalignCount(MisalignCount)
`endif
    );

    always #5 Clk = ~Clk;

    // word memory: combinational read, write on rising edge
    logic [31:0] mem [16];
    assign MemReadData = mem[MemAddress[5:2]];
    always @(posedge Clk)
        if (MemWriteEn) mem[MemAddress[5:2]] <= MemWriteData;

    typedef struct {
        string       name;
        logic [31:0] load;
        logic        stall, merr, we, re;
        bit          chk_mem;
        int          midx;
        logic [31:0] mval;
        bit          chk_cnt;
        logic [31:0] rmw_cnt, mis_cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".LoadData"},    LoadData,            e.load);
            chk({e.name, ".Stall"},       {31'd0, Stall},      {31'd0, e.stall});
            chk({e.name, ".MisalignErr"}, {31'd0, MisalignErr},{31'd0, e.merr});
            chk({e.name, ".MemWriteEn"},  {31'd0, MemWriteEn}, {31'd0, e.we});
            chk({e.name, ".MemReadEn"},   {31'd0, MemReadEn},  {31'd0, e.re});
            if (e.chk_mem)
                chk($sformatf("%s.mem[%0d]", e.name, e.midx), mem[e.midx], e.mval);
`ifdef MEM_ACCESS_STATS_EN
            if (e.chk_cnt) begin
                chk({e.name, ".RmwCount"},      RmwCount,      e.rmw_cnt);
                chk({e.name, ".MisalignCount"}, MisalignCount, e.mis_cnt);
            end
`endif
        end
    end

    task automatic drv(input string nm, input logic r, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sx, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] eload,
                       input logic est, input logic eme, input logic ewe, input logic ere);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst = r; MemRead = rd; MemWrite = wr; Size = sz; SignExt = sx;
        Address = addr; WriteData = wd;
        e.name = nm; e.load = eload; e.stall = est; e.merr = eme; e.we = ewe; e.re = ere;
        e.chk_mem = 1'b0; e.midx = 0; e.mval = '0;
        e.chk_cnt = 1'b0; e.rmw_cnt = '0; e.mis_cnt = '0;
        q.push_back(e);
    endtask

    // attach a memory-content check to the most recently queued cycle
    task automatic mchk(input int idx, input logic [31:0] val);
        q[q.size()-1].chk_mem = 1'b1;
        q[q.size()-1].midx    = idx;
        q[q.size()-1].mval    = val;
    endtask

    task automatic cchk(input logic [31:0] rmw, input logic [31:0] mis);
        q[q.size()-1].chk_cnt = 1'b1;
        q[q.size()-1].rmw_cnt = rmw;
        q[q.size()-1].mis_cnt = mis;
    endtask

    initial begin
        Rst = 1'b1; MemRead = 0; MemWrite = 0; Size = 0; SignExt = 0;
        Address = 0; WriteData = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'hDEADBEEF;
        mem[2] = 32'hCAFEBABE;

        //   name        rst rd wr  size  sx addr    wdata          load          st me we re
        drv("reset",     1, 1, 0, 2'b00, 0, 32'd4,  32'h0,         32'h0,        0, 0, 0, 0);
        drv("sb5_rd",    0, 0, 1, 2'b10, 0, 32'd5,  32'h000000AA,  32'h0,        1, 0, 0, 1);
        mchk(1, 32'hDEADBEEF);
        drv("sb5_wr",    0, 0, 1, 2'b10, 0, 32'd5,  32'h000000AA,  32'h0,        0, 0, 1, 0);
        drv("lb6",       0, 1, 0, 2'b10, 1, 32'd6,  32'h0,         32'hFFFFFFAD, 0, 0, 0, 1);
        mchk(1, 32'hDEADAAEF);
        drv("lbu6",      0, 1, 0, 2'b10, 0, 32'd6,  32'h0,         32'h000000AD, 0, 0, 0, 1);
        drv("sh6_rd",    0, 0, 1, 2'b01, 0, 32'd6,  32'h00001234,  32'h0,        1, 0, 0, 1);
        drv("sh6_wr",    0, 0, 1, 2'b01, 0, 32'd6,  32'h00001234,  32'h0,        0, 0, 1, 0);
        drv("lw4_a",     0, 1, 0, 2'b00, 0, 32'd4,  32'h0,         32'h1234AAEF, 0, 0, 0, 1);
        mchk(1, 32'h1234AAEF);
        drv("sb4_rd",    0, 0, 1, 2'b10, 0, 32'd4,  32'h00000011,  32'h0,        1, 0, 0, 1);
        drv("sb4_wr",    0, 0, 1, 2'b10, 0, 32'd4,  32'h00000011,  32'h0,        0, 0, 1, 0);
        drv("sb7_rd",    0, 0, 1, 2'b10, 0, 32'd7,  32'h00000022,  32'h0,        1, 0, 0, 1);
        mchk(1, 32'h1234AA11);
        drv("sb7_wr",    0, 0, 1, 2'b10, 0, 32'd7,  32'h00000022,  32'h0,        0, 0, 1, 0);
        drv("lw4_b",     0, 1, 0, 2'b00, 0, 32'd4,  32'h0,         32'h2234AA11, 0, 0, 0, 1);
        drv("sh5_mis",   0, 0, 1, 2'b01, 0, 32'd5,  32'h0000BEEF,  32'h0,        0, 0, 0, 0);
        drv("lw6_mis",   0, 1, 0, 2'b00, 0, 32'd6,  32'h0,         32'h0,        0, 1, 0, 0);
        mchk(1, 32'h2234AA11);
        drv("idle_a",    0, 0, 0, 2'b00, 0, 32'd0,  32'h0,         32'h0,        0, 1, 0, 0);
        cchk(32'd4, 32'd2);
        drv("idle_b",    0, 0, 0, 2'b00, 0, 32'd0,  32'h0,         32'h0,        0, 0, 0, 0);
        mchk(1, 32'h2234AA11);
        drv("rdwr_sw12", 0, 1, 1, 2'b00, 0, 32'd12, 32'h0BADF00D,  32'h0,        0, 0, 1, 0);
        drv("lw12",      0, 1, 0, 2'b00, 0, 32'd12, 32'h0,         32'h0BADF00D, 0, 0, 0, 1);
        mchk(3, 32'h0BADF00D);
        drv("lh12",      0, 1, 0, 2'b01, 1, 32'd12, 32'h0,         32'hFFFFF00D, 0, 0, 0, 1);
        drv("lhu14",     0, 1, 0, 2'b01, 0, 32'd14, 32'h0,         32'h00000BAD, 0, 0, 0, 1);
        drv("lw12_sz3",  0, 1, 0, 2'b11, 1, 32'd12, 32'h0,         32'h0BADF00D, 0, 0, 0, 1);
        drv("lbu15",     0, 1, 0, 2'b10, 0, 32'd15, 32'h0,         32'h0000000B, 0, 0, 0, 1);
        drv("sb8_rd",    0, 0, 1, 2'b10, 0, 32'd8,  32'h00000055,  32'h0,        1, 0, 0, 1);
        drv("sb8_rst",   1, 0, 1, 2'b10, 0, 32'd8,  32'h00000055,  32'h0,        0, 0, 0, 0);
        mchk(2, 32'hCAFEBABE);
        drv("post_rst",  0, 0, 0, 2'b00, 0, 32'd0,  32'h0,         32'h0,        0, 0, 0, 0);
        mchk(2, 32'hCAFEBABE);
        drv("lw8",       0, 1, 0, 2'b00, 0, 32'd8,  32'h0,         32'hCAFEBABE, 0, 0, 0, 1);
        mchk(2, 32'hCAFEBABE);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
